// File: rtl/score_display_decoder.sv
// score_display_decoder: recovers a two-digit score from a multiplexed 7-segment bus with stability filtering
module score_display_decoder #(
  parameter int STABLE_SAMPLES = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       invert,
  input  logic [6:0] segments,
  input  logic [1:0] digits,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [6:0] score_bin,
  output logic       valid,
  output logic       blank,
  output logic       changed,
  output logic       err,
  output logic       stale
);
  localparam logic [3:0]  C_S  = 4'(STABLE_SAMPLES);
  localparam logic [15:0] C_TO = 16'(TIMEOUT);
  localparam logic [3:0]  C_BLANK = 4'd15;
  localparam logic [3:0]  C_ILL   = 4'd14;
  logic [6:0]  r_seg;
  logic [1:0]  r_sel;
  logic [3:0]  r_last [2];
  logic [3:0]  r_cnt  [2];
  logic [15:0] r_to;
  logic [3:0]  r_ones, r_tens;
  logic [6:0]  r_bin;
  logic        r_valid, r_blank, r_changed, r_err, r_stale;
  logic [3:0]  w_code;
  logic        w_legal, w_idx, w_tmo, w_both, w_dec, w_blk, w_ill;
  logic [6:0]  w_bin;
  function automatic logic [3:0] seg2code(input logic [6:0] s);
    case (s)
      7'h3F:   seg2code = 4'd0;
      7'h06:   seg2code = 4'd1;
      7'h5B:   seg2code = 4'd2;
      7'h4F:   seg2code = 4'd3;
      7'h66:   seg2code = 4'd4;
      7'h6D:   seg2code = 4'd5;
      7'h7D:   seg2code = 4'd6;
      7'h07:   seg2code = 4'd7;
      7'h7F:   seg2code = 4'd8;
      7'h6F:   seg2code = 4'd9;
      7'h00:   seg2code = C_BLANK;
      default: seg2code = C_ILL;
    endcase
  endfunction
  // decode the registered sample and evaluate acceptance of both digits
  always_comb begin
    w_code  = seg2code(r_seg);
    w_legal = (r_sel == 2'b01) || (r_sel == 2'b10);
    w_idx   = r_sel[1];
    w_tmo   = !w_legal && (r_to >= C_TO);
    w_both  = (r_cnt[0] == C_S) && (r_cnt[1] == C_S) && !w_tmo;
    w_dec   = (r_last[0] < 4'd10) && (r_last[1] < 4'd10);
    w_blk   = (r_last[0] == C_BLANK) && (r_last[1] == C_BLANK);
    w_ill   = (r_last[0] == C_ILL) || (r_last[1] == C_ILL);
    w_bin   = 7'(r_last[1]) * 7'd10 + 7'(r_last[0]);
  end
  // stage 1: normalised bus sample; a disabled decoder sees no digit select
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_sel <= '0;
    end else if (!ena) begin
      r_sel <= '0;
    end else begin
      r_seg <= invert ? ~segments : segments;
      r_sel <= invert ? ~digits : digits;
    end
  end
  // stage 2: per-digit stability counters and the no-select timeout counter
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      r_last[0] <= '0;
      r_last[1] <= '0;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
      r_to      <= '0;
    end else if (w_legal) begin
      r_to           <= '0;
      r_last[w_idx]  <= w_code;
      r_cnt[w_idx]   <= (w_code == r_last[w_idx]) ? ((r_cnt[w_idx] == C_S) ? C_S : r_cnt[w_idx] + 4'd1) : 4'd1;
    end else begin
      r_to <= (r_to == 16'hFFFF) ? r_to : r_to + 16'd1;
      if (w_tmo) begin
        r_cnt[0] <= '0;
        r_cnt[1] <= '0;
      end
    end
  end
  // stage 3: commit accepted digits to the score outputs and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ones    <= '0;
      r_tens    <= '0;
      r_bin     <= '0;
      r_valid   <= 1'b0;
      r_blank   <= 1'b0;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
      r_stale   <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (ena) begin
        if (w_legal) r_stale <= 1'b0;
        else if (w_tmo) begin
          r_stale <= 1'b1;
          r_valid <= 1'b0;
        end
        if (w_both) begin
          if (w_ill) r_err <= 1'b1;
          else if (w_dec) begin
            r_ones    <= r_last[0];
            r_tens    <= r_last[1];
            r_bin     <= w_bin;
            r_valid   <= 1'b1;
            r_blank   <= 1'b0;
            r_changed <= !r_valid || ({r_last[1], r_last[0]} != {r_tens, r_ones});
          end else if (w_blk) begin
            r_valid <= 1'b0;
            r_blank <= 1'b1;
          end
        end
      end
    end
  end
  assign score_ones = r_ones;
  assign score_tens = r_tens;
  assign score_bin  = r_bin;
  assign valid      = r_valid;
  assign blank      = r_blank;
  assign changed    = r_changed;
  assign err        = r_err;
  assign stale      = r_stale;
endmodule
